multicycle_ctrl: RTL and testbench

// Multi-cycle control FSM that sequences the yIF/yID/yEX/yDM/yWB datapath.

---
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle control FSM for the yIF/yID/yEX/yDM/yWB datapath.
// Owns the PC, latches the fetched instruction, decodes its opcode and drives
// the per-phase datapath controls as Moore outputs of (state, ir).
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start               IDLE/HALT -> FETCH, reloads pc=ENTRY, clears retired/illegal
//   ins                 instruction word from yIF for the current pc
//   zero                ALU zero flag from yEX (sampled on a branch's retire edge)
//   PCp4/branch/jTarget next-pc candidates from yIF/yID
//   pc                  PC register (feeds yIF PCin)
//   RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op   datapath controls
//   busy, halted        FETCH..WB / HALT indicators
//   illegal             sticky unknown-opcode flag
//   retired[15:0]       saturating retired-instruction count
module multicycle_ctrl #(
  parameter logic [31:0] ENTRY     = 32'h28,
  parameter int unsigned MAX_INSNS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] PCp4,
  input  logic [31:0] branch,
  input  logic [31:0] jTarget,
  output logic [31:0] pc,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic [2:0]  op,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LD  = 7'h03;
  localparam logic [6:0] OPC_ST  = 7'h23;
  localparam logic [6:0] OPC_BR  = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;

  // Opcode classes of the latched instruction
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_legal;
  logic       br_taken, hit_max, retire;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign is_r     = (opcode == OPC_R);
  assign is_i     = (opcode == OPC_I);
  assign is_ld    = (opcode == OPC_LD);
  assign is_st    = (opcode == OPC_ST);
  assign is_br    = (opcode == OPC_BR);
  assign is_jal   = (opcode == OPC_JAL);
  assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal;

  // beq taken on zero, bne on !zero; any other funct3 falls through
  assign br_taken = is_br & (((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero));

  // Compared in 32 bits so a count that saturates can never wrap into a match
  assign hit_max = (MAX_INSNS != 0) && ((32'(retired_q) + 32'd1) == MAX_INSNS);

  // Register fields the controller never looks at
  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= ENTRY;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = ENTRY;
          retired_d = '0;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = ins;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!is_legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r || is_i)       state_d = S_WB;
        else if (is_ld || is_st) state_d = S_MEM;
        else                     retire  = 1'b1;
      end
      S_MEM: begin
        if (is_ld) state_d = S_WB;
        else       retire  = 1'b1;
      end
      S_WB:    retire = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Common retire edge: pc update, count, and loop or stop
    if (retire) begin
      if (br_taken)    pc_d = branch;
      else if (is_jal) pc_d = jTarget;
      else             pc_d = PCp4;
      if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
      state_d = hit_max ? S_HALT : S_FETCH;
    end
  end

  // Moore controls
  logic in_alu;
  assign in_alu = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    op       = ALU_ADD;
    if (in_alu) begin
      ALUSrc = is_i | is_ld | is_st;
      if (is_r || is_i) begin
        unique case (funct3)
          3'b000:  op = (is_r && ir_q[30]) ? ALU_SUB : ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          3'b010:  op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end else if (is_br) begin
        op = ALU_SUB;
      end
    end
    if ((state_q == S_MEM || state_q == S_WB) && is_ld) begin
      MemRead = 1'b1;
      Mem2Reg = 1'b1;
    end
    if (state_q == S_MEM && is_st) MemWrite = 1'b1;
    // Only R/I-ALU/load ever reach WB
    if (state_q == S_WB) RegWrite = 1'b1;
  end

  assign pc      = pc_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  ctl;   // {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg}
    logic [2:0]  op;
    logic [2:0]  bhi;   // {busy, halted, illegal}
    logic [15:0] ret;
  } outs_t;

  typedef struct {
    logic        start;
    logic [31:0] ins;
    logic        zero;
    logic [31:0] pcp4;
    logic [31:0] br;
    logic [31:0] jt;
    outs_t       exp;
  } vec_t;

  localparam logic [4:0] RW = 5'b10000, AS = 5'b01000, MR = 5'b00100,
                         MW = 5'b00010, M2 = 5'b00001;
  localparam logic [2:0] B = 3'b100, H = 3'b010, I = 3'b001;
  localparam logic [2:0] ADDo = 3'b010, SUBo = 3'b110, ORo = 3'b001;

  localparam logic [31:0] ADD = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] SUB = 32'h402081B3;  // sub x3,x1,x2
  localparam logic [31:0] LW  = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] SW  = 32'h0050A223;  // sw x5,4(x1)
  localparam logic [31:0] BEQ = 32'h00208863;  // beq x1,x2
  localparam logic [31:0] BNE = 32'h00209863;  // bne x1,x2
  localparam logic [31:0] JAL = 32'h008000EF;  // jal x1
  localparam logic [31:0] ORI = 32'h0050E093;  // ori x1,x1,5
  localparam logic [31:0] BAD = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset, start, zero;
  logic [31:0] ins, PCp4, branch, jTarget;

  logic [31:0] pc_a, pc_b;
  logic        rw_a, as_a, mr_a, mw_a, m2_a, busy_a, halt_a, ill_a;
  logic        rw_b, as_b, mr_b, mw_b, m2_b, busy_b, halt_b, ill_b;
  logic [2:0]  op_a, op_b;
  logic [15:0] ret_a, ret_b;

  multicycle_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .ins(ins), .zero(zero),
    .PCp4(PCp4), .branch(branch), .jTarget(jTarget), .pc(pc_a),
    .RegWrite(rw_a), .ALUSrc(as_a), .MemRead(mr_a), .MemWrite(mw_a),
    .Mem2Reg(m2_a), .op(op_a), .busy(busy_a), .halted(halt_a),
    .illegal(ill_a), .retired(ret_a)
  );

  multicycle_ctrl #(.MAX_INSNS(1)) u_lim (
    .clk(clk), .reset(reset), .start(start), .ins(ins), .zero(zero),
    .PCp4(PCp4), .branch(branch), .jTarget(jTarget), .pc(pc_b),
    .RegWrite(rw_b), .ALUSrc(as_b), .MemRead(mr_b), .MemWrite(mw_b),
    .Mem2Reg(m2_b), .op(op_b), .busy(busy_b), .halted(halt_b),
    .illegal(ill_b), .retired(ret_b)
  );

  outs_t act_a, act_b;
  assign act_a = {pc_a, rw_a, as_a, mr_a, mw_a, m2_a, op_a, busy_a, halt_a, ill_a, ret_a};
  assign act_b = {pc_b, rw_b, as_b, mr_b, mw_b, m2_b, op_b, busy_b, halt_b, ill_b, ret_b};

  always #5 clk = ~clk;

  int   errs = 0;
  int   checks = 0;
  vec_t tbl[$];

  function automatic outs_t o(logic [31:0] p, logic [4:0] c, logic [2:0] alu,
                              logic [2:0] f, logic [15:0] r);
    return {p, c, alu, f, r};
  endfunction

  function automatic string fmt(outs_t x);
    return $sformatf("pc=%h ctl=%b op=%b bhi=%b ret=%0d", x.pc, x.ctl, x.op, x.bhi, x.ret);
  endfunction

  task automatic v(logic s, logic [31:0] i, logic z, logic [31:0] p4,
                   logic [31:0] br, logic [31:0] jt, outs_t e);
    vec_t r;
    r.start = s; r.ins = i; r.zero = z; r.pcp4 = p4; r.br = br; r.jt = jt; r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic chk(string name, outs_t a, outs_t e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %s want %s", name, fmt(a), fmt(e));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic s, logic [31:0] i, logic z, logic [31:0] p4,
                       logic [31:0] br, logic [31:0] jt);
    start = s; ins = i; zero = z; PCp4 = p4; branch = br; jTarget = jt;
  endtask

  initial begin
    // Each row: inputs applied before an edge, outputs expected after it
    v(1, ADD, 0, 32'h2C, 0, 0, o(32'h28, 0,            ADDo, B, 0));  // FETCH
    v(0, ADD, 0, 32'h2C, 0, 0, o(32'h28, 0,            ADDo, B, 0));  // DECODE
    v(0, ADD, 0, 32'h2C, 0, 0, o(32'h28, 0,            ADDo, B, 0));  // EXEC
    v(0, ADD, 0, 32'h2C, 0, 0, o(32'h28, RW,           ADDo, B, 0));  // WB
    v(0, ADD, 0, 32'h2C, 0, 0, o(32'h2C, 0,            ADDo, B, 1));  // retire
    v(0, SUB, 0, 32'h30, 0, 0, o(32'h2C, 0,            ADDo, B, 1));
    v(1, SUB, 0, 32'h30, 0, 0, o(32'h2C, 0,            SUBo, B, 1));  // start ignored
    v(0, SUB, 0, 32'h30, 0, 0, o(32'h2C, RW,           SUBo, B, 1));
    v(0, SUB, 0, 32'h30, 0, 0, o(32'h30, 0,            ADDo, B, 2));
    v(0, LW,  0, 32'h34, 0, 0, o(32'h30, 0,            ADDo, B, 2));
    v(0, LW,  0, 32'h34, 0, 0, o(32'h30, AS,           ADDo, B, 2));
    v(0, LW,  0, 32'h34, 0, 0, o(32'h30, AS|MR|M2,     ADDo, B, 2));  // MEM
    v(0, LW,  0, 32'h34, 0, 0, o(32'h30, RW|AS|MR|M2,  ADDo, B, 2));  // WB
    v(0, LW,  0, 32'h34, 0, 0, o(32'h34, 0,            ADDo, B, 3));
    v(0, SW,  0, 32'h38, 0, 0, o(32'h34, 0,            ADDo, B, 3));
    v(0, SW,  0, 32'h38, 0, 0, o(32'h34, AS,           ADDo, B, 3));
    v(0, SW,  0, 32'h38, 0, 0, o(32'h34, AS|MW,        ADDo, B, 3));  // MEM
    v(0, SW,  0, 32'h38, 0, 0, o(32'h38, 0,            ADDo, B, 4));
    v(0, BEQ, 1, 32'h3C, 32'h40, 0, o(32'h38, 0,       ADDo, B, 4));
    v(0, BEQ, 1, 32'h3C, 32'h40, 0, o(32'h38, 0,       SUBo, B, 4));
    v(0, BEQ, 1, 32'h3C, 32'h40, 0, o(32'h40, 0,       ADDo, B, 5));  // taken
    v(0, BNE, 1, 32'h44, 32'h80, 0, o(32'h40, 0,       ADDo, B, 5));
    v(0, BNE, 1, 32'h44, 32'h80, 0, o(32'h40, 0,       SUBo, B, 5));
    v(0, BNE, 1, 32'h44, 32'h80, 0, o(32'h44, 0,       ADDo, B, 6));  // not taken
    v(0, BEQ, 0, 32'h48, 32'h80, 0, o(32'h44, 0,       ADDo, B, 6));
    v(0, BEQ, 0, 32'h48, 32'h80, 0, o(32'h44, 0,       SUBo, B, 6));
    v(0, BEQ, 0, 32'h48, 32'h80, 0, o(32'h48, 0,       ADDo, B, 7));  // not taken
    v(0, JAL, 0, 32'h4C, 0, 32'h100, o(32'h48, 0,      ADDo, B, 7));
    v(0, JAL, 0, 32'h4C, 0, 32'h100, o(32'h48, 0,      ADDo, B, 7));
    v(0, JAL, 0, 32'h4C, 0, 32'h100, o(32'h100, 0,     ADDo, B, 8));
    v(0, ORI, 0, 32'h104, 0, 0, o(32'h100, 0,          ADDo, B, 8));
    v(0, ORI, 0, 32'h104, 0, 0, o(32'h100, AS,         ORo,  B, 8));
    v(0, ORI, 0, 32'h104, 0, 0, o(32'h100, RW|AS,      ORo,  B, 8));
    v(0, ORI, 0, 32'h104, 0, 0, o(32'h104, 0,          ADDo, B, 9));
    v(0, BAD, 0, 32'h108, 0, 0, o(32'h104, 0,          ADDo, B, 9));  // DECODE
    v(0, BAD, 0, 32'h108, 0, 0, o(32'h104, 0,          ADDo, H|I, 9));
    v(0, BAD, 0, 32'h108, 0, 0, o(32'h104, 0,          ADDo, H|I, 9));  // holds
    v(1, ADD, 0, 32'h2C, 0, 0, o(32'h28, 0,            ADDo, B, 0));  // restart

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(); step();
    chk("reset", act_a, o(32'h28, 0, ADDo, 0, 0));
    reset = 1'b0;
    step();
    chk("idle_hold", act_a, o(32'h28, 0, ADDo, 0, 0));

    // Main program trace
    foreach (tbl[k]) begin
      drive(tbl[k].start, tbl[k].ins, tbl[k].zero, tbl[k].pcp4, tbl[k].br, tbl[k].jt);
      step();
      chk($sformatf("vec%0d", k), act_a, tbl[k].exp);
    end

    // MAX_INSNS=1: add retires and halts; unlimited instance keeps fetching
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1, ADD, 0, 32'h2C, 0, 0);
    step();
    chk("lim_fetch", act_b, o(32'h28, 0, ADDo, B, 0));
    start = 1'b0;
    step();
    chk("lim_decode", act_b, o(32'h28, 0, ADDo, B, 0));
    step();
    chk("lim_exec", act_b, o(32'h28, 0, ADDo, B, 0));
    step();
    chk("lim_wb", act_b, o(32'h28, RW, ADDo, B, 0));
    step();
    chk("lim_halt", act_b, o(32'h2C, 0, ADDo, H, 1));
    chk("nolim_fetch", act_a, o(32'h2C, 0, ADDo, B, 1));
    step();
    chk("lim_hold", act_b, o(32'h2C, 0, ADDo, H, 1));

    // Reset in the MEM cycle of a load, then rerun from ENTRY
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1, LW, 0, 32'h2C, 0, 0);
    step();
    start = 1'b0;
    step(); step(); step();
    chk("ld_mem", act_a, o(32'h28, AS|MR|M2, ADDo, B, 0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_idle", act_a, o(32'h28, 0, ADDo, 0, 0));
    step();
    chk("abort_hold", act_a, o(32'h28, 0, ADDo, 0, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rerun_fetch", act_a, o(32'h28, 0, ADDo, B, 0));
    step(); step(); step();
    chk("rerun_mem", act_a, o(32'h28, AS|MR|M2, ADDo, B, 0));
    step();
    chk("rerun_wb", act_a, o(32'h28, RW|AS|MR|M2, ADDo, B, 0));
    step();
    chk("rerun_retire", act_a, o(32'h2C, 0, ADDo, B, 1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
